ir_loader: RTL and testbench
============================

# ir_loader

Writer side of the instruction-register file. It accepts a byte stream from the boot device and assembles instruction words from it. It writes those words into the IR regfile at addresses 0..N-1, then raises the init-finished flag that the IR fetch side waits on before it leaves its init state. It sits between the device byte interface and the IR regfile write port.

## Interface
- `DATA_WIDTH`, default 8: width of one device byte; equals `` `DATA_WIDTH ``.
- `IR_WIDTH`, default 16: instruction word width; must be a multiple of `DATA_WIDTH`.
- `IR_ADDR_WIDTH`, default 8: IR regfile address width; must be ≥ `DATA_WIDTH`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `i_start` in 1: begin a load; level-sampled.
- `i_byte` in `DATA_WIDTH`: device byte.
- `i_byte_valid` in 1: `i_byte` is valid.
- `o_byte_ready` out 1: loader accepts a byte this cycle.
- `o_ir_wr_en` out 1: IR regfile write strobe, one cycle per word.
- `o_ir_wr_addr` out `IR_ADDR_WIDTH`: write address.
- `o_ir_wr_data` out `IR_WIDTH`: write data.
- `o_init_finished` out 1: load complete; held high.
- `o_busy` out 1: high in LEN, COLLECT and WRITE.

## Operation
- Byte accepted iff `i_byte_valid && o_byte_ready` in the same cycle.
- State machine: IDLE → LEN → COLLECT ⇄ WRITE → DONE.
- **IDLE**
  - `o_byte_ready` = 0.
  - `i_start` = 1 → LEN; clears the word counter and byte index.
- **LEN**
  - `o_byte_ready` = 1.
  - The accepted byte is the word count N; it is zero-extended to `IR_ADDR_WIDTH`.
  - N == 0 → DONE, with no writes.
  - Otherwise → COLLECT.
- **COLLECT**
  - `o_byte_ready` = 1.
  - Bytes fill the word little-endian: byte k goes to bits [k·DATA_WIDTH +: DATA_WIDTH].
  - After byte `IR_WIDTH/DATA_WIDTH`−1 is accepted → WRITE.
- **WRITE**
  - Lasts exactly one cycle, with `o_byte_ready` = 0.
  - Outputs: `o_ir_wr_en` = 1, `o_ir_wr_addr` = word counter, `o_ir_wr_data` = assembled word.
  - Word counter increments; byte index clears.
  - If counter+1 == N → DONE; otherwise → COLLECT.
- **DONE**
  - `o_init_finished` = 1 and `o_byte_ready` = 0.
  - `i_start` = 1 → LEN, and `o_init_finished` drops in that same transition.
- `i_start` is ignored in LEN, COLLECT and WRITE.
- Bytes offered while `o_byte_ready` = 0 are not consumed. The device must hold them.
- The word counter never wraps: N ≤ 2^DATA_WIDTH − 1 ≤ 2^IR_ADDR_WIDTH − 1.
- Reset in any state:
  - FSM → IDLE; all counters and the assembly register → 0.
  - All outputs take their reset values on the next edge.
  - A partially assembled word is discarded and never written.

## Timing
- Reset values: `o_byte_ready` = 0, `o_ir_wr_en` = 0, `o_ir_wr_addr` = 0, `o_ir_wr_data` = 0, `o_init_finished` = 0, `o_busy` = 0.
- All outputs are registered or decoded from registered state; there are no combinational input→output paths.
- `i_start` sampled high at edge t → `o_byte_ready` = 1 from t+1.
- Last byte of a word accepted at edge t → `o_ir_wr_en` high during cycle t+1 → next byte can be accepted at edge t+2.
- Final write in cycle t+1 → `o_init_finished` high from t+2.
- Header N == 0 accepted at edge t → `o_init_finished` high from t+1.
- Throughput with `i_byte_valid` held high: one word per `IR_WIDTH/DATA_WIDTH`+1 cycles.
- `o_ir_wr_addr` and `o_ir_wr_data` are held stable outside WRITE. Only `o_ir_wr_en` qualifies them.

## Structure
- Shared constants go in `define.v`: `` `DATA_WIDTH ``, `` `IR_WIDTH ``, `` `IR_ADDR_WIDTH ``, and the state encodings `` `LD_IDLE ``, `` `LD_LEN ``, `` `LD_COLLECT ``, `` `LD_WRITE ``, `` `LD_DONE `` (3 bits).
- One sub-module, `ir_word_assembler`, holds:
  - the byte index counter;
  - the little-endian lane write into the word register;
  - a `last_byte` flag;
  - clear and load inputs driven by the FSM.
- The FSM, word counter, N register and output registers live in `ir_loader`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `i_byte_valid` = 1 → all outputs 0, no byte consumed.
- **Basic load:** `i_start`, then bytes 02 01 02 03 04 with valid held high →
  - writes (0, 0x0201) and (1, 0x0403), each a one-cycle `o_ir_wr_en`;
  - `o_init_finished` high the cycle after the second write.
- **Empty load:** `i_start`, header 00 → no `o_ir_wr_en`; `o_init_finished` high one cycle after the header is accepted.
- **Valid gaps:** header 01, then AA and BB with 3 idle cycles between bytes → a single write (0, 0xBBAA). Bytes offered during WRITE are not consumed.
- **Reset mid-load:** assert `rst` after byte AA of word 1 → all outputs 0. A fresh load of 01 11 22 then writes (0, 0x2211) only.
- **Restart:** from DONE, pulse `i_start` → `o_init_finished` falls on the next edge. A new load of 01 33 44 writes (0, 0x4433).

Source files
------------

// File: rtl/ir_loader_pkg.sv
// ir_loader_pkg: shared widths and FSM state encodings for the IR loader
package ir_loader_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int IR_WIDTH = 16;
  localparam int IR_ADDR_WIDTH = 8;
  localparam logic [2:0] LD_IDLE = 3'd0;
  localparam logic [2:0] LD_LEN = 3'd1;
  localparam logic [2:0] LD_COLLECT = 3'd2;
  localparam logic [2:0] LD_WRITE = 3'd3;
  localparam logic [2:0] LD_DONE = 3'd4;
endpackage

// File: rtl/ir_word_assembler.sv
// ir_word_assembler: packs device bytes little-endian into one instruction word
// ports: clk, rst (sync, active-high); clear resets the byte index; load writes
// byte_in into the current lane; word_nx is the word including this cycle's byte;
// last_byte flags that the current lane is the final one of the word.
module ir_word_assembler
  import ir_loader_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int IW = IR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] byte_in,
  output logic [IW-1:0] word_nx,
  output logic          last_byte
);
  localparam int NB = IW / DW;
  localparam int IDX_W = NB > 1 ? $clog2(NB) : 1;
  logic [IDX_W-1:0] idx;
  logic [IW-1:0] word;
  assign last_byte = idx == IDX_W'(NB - 1);
  always_comb begin
    word_nx = word;
    word_nx[idx*DW +: DW] = byte_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      word <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (load) begin
      word <= word_nx;
      idx <= last_byte ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/ir_loader.sv
// ir_loader: loads a length-prefixed byte stream into the IR regfile, then flags init done
// ports: clk, rst (sync, active-high); i_start begins a load; i_byte/i_byte_valid
// with o_byte_ready form the device byte handshake; o_ir_wr_en/addr/data drive the
// IR regfile write port; o_init_finished holds high after a load; o_busy while loading.
module ir_loader
  import ir_loader_pkg::*;
#(
  parameter int DATA_WIDTH = ir_loader_pkg::DATA_WIDTH,
  parameter int IR_WIDTH = ir_loader_pkg::IR_WIDTH,
  parameter int IR_ADDR_WIDTH = ir_loader_pkg::IR_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [DATA_WIDTH-1:0]    i_byte,
  input  logic                     i_byte_valid,
  output logic                     o_byte_ready,
  output logic                     o_ir_wr_en,
  output logic [IR_ADDR_WIDTH-1:0] o_ir_wr_addr,
  output logic [IR_WIDTH-1:0]      o_ir_wr_data,
  output logic                     o_init_finished,
  output logic                     o_busy
);
  logic [2:0] state, state_nx;
  logic [IR_ADDR_WIDTH-1:0] cnt, n;
  logic [IR_WIDTH-1:0] word_nx;
  logic last_byte, acc, start_ok, load, clear;
  assign o_byte_ready = state == LD_LEN || state == LD_COLLECT;
  assign o_ir_wr_en = state == LD_WRITE;
  assign o_init_finished = state == LD_DONE;
  assign o_busy = state == LD_LEN || state == LD_COLLECT || state == LD_WRITE;
  assign acc = i_byte_valid && o_byte_ready;
  assign start_ok = i_start && (state == LD_IDLE || state == LD_DONE);
  assign load = acc && state == LD_COLLECT;
  assign clear = start_ok || state == LD_WRITE;
  ir_word_assembler #(.DW(DATA_WIDTH), .IW(IR_WIDTH)) u_asm (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .load(load),
    .byte_in(i_byte),
    .word_nx(word_nx),
    .last_byte(last_byte)
  );
  always_comb begin
    state_nx = state;
    case (state)
      LD_IDLE, LD_DONE: state_nx = i_start ? LD_LEN : state;
      LD_LEN: state_nx = !acc ? LD_LEN : i_byte == '0 ? LD_DONE : LD_COLLECT;
      LD_COLLECT: state_nx = acc && last_byte ? LD_WRITE : LD_COLLECT;
      LD_WRITE: state_nx = cnt + 1'b1 == n ? LD_DONE : LD_COLLECT;
      default: state_nx = LD_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LD_IDLE;
      cnt <= '0;
      n <= '0;
      o_ir_wr_addr <= '0;
      o_ir_wr_data <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) cnt <= '0;
      if (state == LD_WRITE) cnt <= cnt + 1'b1;
      if (state == LD_LEN && acc) n <= IR_ADDR_WIDTH'(i_byte);
      if (load && last_byte) begin
        o_ir_wr_addr <= cnt;
        o_ir_wr_data <= word_nx;
      end
    end
  end
endmodule

// File: tb/tb_ir_loader.sv
// tb_ir_loader: directed self-checking bench for ir_loader
module tb_ir_loader;
  logic clk = 0, rst = 1, i_start = 0, i_byte_valid = 0;
  logic [7:0] i_byte = 0;
  logic o_byte_ready, o_ir_wr_en, o_init_finished, o_busy;
  logic [7:0] o_ir_wr_addr;
  logic [15:0] o_ir_wr_data;
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [7:0] wa[$];
  logic [15:0] wd[$];
  int wc[$];
  ir_loader dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_byte(i_byte),
    .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready),
    .o_ir_wr_en(o_ir_wr_en),
    .o_ir_wr_addr(o_ir_wr_addr),
    .o_ir_wr_data(o_ir_wr_data),
    .o_init_finished(o_init_finished),
    .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_ir_wr_en) begin
      wa.push_back(o_ir_wr_addr);
      wd.push_back(o_ir_wr_data);
      wc.push_back(cyc);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [7:0] b);
    i_byte = b;
    i_byte_valid = 1;
    for (int k = 0; k < 8 && !o_byte_ready; k++) tick();
    chk("ready_wait", o_byte_ready, 1);
    tick();
    i_byte_valid = 0;
  endtask
  task automatic start;
    i_start = 1;
    tick();
    i_start = 0;
  endtask
  task automatic clr_log;
    wa.delete();
    wd.delete();
    wc.delete();
  endtask
  initial begin
    i_byte_valid = 1;
    i_byte = 8'h55;
    tick();
    tick();
    chk("rst_ready", o_byte_ready, 0);
    chk("rst_wr_en", o_ir_wr_en, 0);
    chk("rst_addr", o_ir_wr_addr, 0);
    chk("rst_data", o_ir_wr_data, 0);
    chk("rst_fin", o_init_finished, 0);
    chk("rst_busy", o_busy, 0);
    rst = 0;
    tick();
    chk("idle_ready", o_byte_ready, 0);
    i_byte_valid = 0;
    chk("idle_no_wr", wa.size(), 0);
    clr_log();
    start();
    chk("basic_ready", o_byte_ready, 1);
    chk("basic_busy", o_busy, 1);
    put(8'h02);
    put(8'h01);
    put(8'h02);
    chk("w0_en", o_ir_wr_en, 1);
    chk("w0_addr", o_ir_wr_addr, 0);
    chk("w0_data", o_ir_wr_data, 16'h0201);
    chk("w0_ready", o_byte_ready, 0);
    put(8'h03);
    chk("mid_en", o_ir_wr_en, 0);
    put(8'h04);
    chk("w1_en", o_ir_wr_en, 1);
    chk("w1_addr", o_ir_wr_addr, 1);
    chk("w1_data", o_ir_wr_data, 16'h0403);
    chk("w1_fin_low", o_init_finished, 0);
    tick();
    chk("basic_fin", o_init_finished, 1);
    chk("basic_en_off", o_ir_wr_en, 0);
    chk("basic_busy_off", o_busy, 0);
    chk("basic_hold", o_ir_wr_data, 16'h0403);
    chk("basic_nwr", wa.size(), 2);
    chk("basic_a0", wa[0], 0);
    chk("basic_d0", wd[0], 16'h0201);
    chk("basic_a1", wa[1], 1);
    chk("basic_d1", wd[1], 16'h0403);
    chk("basic_gap", wc[1] - wc[0], 3);
    clr_log();
    start();
    chk("empty_fin_drop", o_init_finished, 0);
    put(8'h00);
    chk("empty_fin", o_init_finished, 1);
    tick();
    tick();
    chk("empty_nwr", wa.size(), 0);
    clr_log();
    start();
    put(8'h01);
    repeat (3) tick();
    put(8'hAA);
    repeat (3) tick();
    chk("gap_noearly", wa.size(), 0);
    put(8'hBB);
    chk("gap_en", o_ir_wr_en, 1);
    chk("gap_addr", o_ir_wr_addr, 0);
    chk("gap_data", o_ir_wr_data, 16'hBBAA);
    i_byte = 8'hCC;
    i_byte_valid = 1;
    tick();
    chk("gap_done_ready", o_byte_ready, 0);
    chk("gap_fin", o_init_finished, 1);
    tick();
    i_byte_valid = 0;
    chk("gap_nwr", wa.size(), 1);
    clr_log();
    start();
    put(8'h02);
    put(8'hAA);
    chk("mid_busy", o_busy, 1);
    rst = 1;
    i_byte_valid = 1;
    i_byte = 8'hBB;
    tick();
    chk("mrst_ready", o_byte_ready, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_data", o_ir_wr_data, 0);
    tick();
    rst = 0;
    i_byte_valid = 0;
    chk("mrst_fin", o_init_finished, 0);
    chk("mrst_en", o_ir_wr_en, 0);
    chk("mrst_nwr", wa.size(), 0);
    start();
    put(8'h01);
    put(8'h11);
    put(8'h22);
    tick();
    chk("fresh_fin", o_init_finished, 1);
    chk("fresh_nwr", wa.size(), 1);
    chk("fresh_a0", wa[0], 0);
    chk("fresh_d0", wd[0], 16'h2211);
    clr_log();
    i_start = 1;
    tick();
    i_start = 0;
    chk("rs_fin_drop", o_init_finished, 0);
    chk("rs_ready", o_byte_ready, 1);
    put(8'h01);
    put(8'h33);
    put(8'h44);
    tick();
    chk("rs_fin", o_init_finished, 1);
    chk("rs_nwr", wa.size(), 1);
    chk("rs_a0", wa[0], 0);
    chk("rs_d0", wd[0], 16'h4433);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
